// File: rtl/avalon_pio_in_irq_pkg.sv
// Shared constants for the Avalon-MM input PIO slave.
//   ADDR_*  : word addresses of the register map
//   EDGE_*  : values of the EDGE_TYPE capture-mode parameter
package pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_in_irq_if.sv
// Avalon-MM slave bus bundle of the input PIO.
//   address    : word address (data, reserved, irqmask, edgecapture)
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data
//   readdata   : registered read data, latency 1
//   irq        : level interrupt, active-high
interface avalon_pio_in_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/avalon_pio_in_irq_sync_bank.sv
// Per-bit multi-flop synchroniser for asynchronous input pins.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset, clears every stage
//   i_async  : raw pin values
//   o_sync   : synchronised values, SYNC_STAGES cycles behind i_async
module pio_sync_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  // Stage 0 is the metastable catcher; the last stage is the clean output.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

  // Shift the pin values through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/avalon_pio_in_irq.sv
// Parametrised Avalon-MM input PIO slave with edge capture and level IRQ.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   i_in_port  : asynchronous external inputs, WIDTH bits
//   bus        : Avalon-MM slave (address, chipselect, write_n, writedata,
//                readdata, irq)
// Register map: 0 data (synchronised pins, read-only), 1 reserved (reads 0),
// 2 irqmask, 3 edgecapture (write-1-to-clear, sticky).
module avalon_pio_in_irq
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    i_in_port,
  avalon_pio_in_irq_if.slave  bus
);

  generate
    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_param_check
      $error("avalon_pio_in_irq: illegal WIDTH, SYNC_STAGES or EDGE_TYPE");
    end
  endgenerate

  logic [WIDTH-1:0]   w_sync;
  logic [WIDTH-1:0]   w_wd;
  logic [WIDTH-1:0]   w_rise;
  logic [WIDTH-1:0]   w_fall;
  logic [WIDTH-1:0]   w_sel;
  logic [WIDTH-1:0]   w_new_edges;
  logic [WIDTH-1:0]   w_edge_next;
  logic [WIDTH-1:0]   w_mask_next;
  logic [31:0]        w_rd;
  logic               w_wr_en;
  logic               w_armed;
  logic               w_unused;

  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_edge;
  logic [WIDTH-1:0]   r_mask;
  logic [31:0]        r_readdata;
  logic               r_irq;
  // A 1 walks up this chain after reset; the top bit marks the first cycle
  // in which both sync and prev hold real pin values.
  logic [SYNC_STAGES:0] r_arm_sr;

  pio_sync_bank #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (i_in_port),
    .o_sync  (w_sync)
  );

  assign w_wd     = bus.writedata[WIDTH-1:0];
  assign w_unused = ^bus.writedata;
  assign w_wr_en  = bus.chipselect & ~bus.write_n;
  assign w_armed  = r_arm_sr[SYNC_STAGES];

  // Edge detection, gated until the pipeline holds real pin history.
  always_comb begin
    w_rise = w_sync & ~r_prev;
    w_fall = ~w_sync & r_prev;
    case (EDGE_TYPE)
      EDGE_RISE: w_sel = w_rise;
      EDGE_FALL: w_sel = w_fall;
      default:   w_sel = w_rise | w_fall;
    endcase
    if (w_armed) begin
      w_new_edges = w_sel;
    end else begin
      w_new_edges = '0;
    end
  end

  // Next values of irqmask and edgecapture; a fresh edge beats a clear.
  always_comb begin
    w_mask_next = r_mask;
    w_edge_next = r_edge | w_new_edges;
    if (w_wr_en && bus.address == ADDR_MASK) begin
      w_mask_next = w_wd;
    end else begin
      w_mask_next = r_mask;
    end
    if (w_wr_en && bus.address == ADDR_EDGE) begin
      w_edge_next = (r_edge & ~w_wd) | w_new_edges;
    end else begin
      w_edge_next = r_edge | w_new_edges;
    end
  end

  // Read mux; reads see the register contents before this cycle's write.
  always_comb begin
    w_rd = 32'h0000_0000;
    case (bus.address)
      ADDR_DATA: w_rd[WIDTH-1:0] = w_sync;
      ADDR_RSVD: w_rd = 32'h0000_0000;
      ADDR_MASK: w_rd[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rd[WIDTH-1:0] = r_edge;
      default:   w_rd = 32'h0000_0000;
    endcase
  end

  // State registers, registered read data and irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_edge     <= '0;
      r_mask     <= RESET_MASK;
      r_readdata <= 32'h0000_0000;
      r_irq      <= 1'b0;
      r_arm_sr   <= '0;
    end else begin
      r_prev     <= w_sync;
      r_edge     <= w_edge_next;
      r_mask     <= w_mask_next;
      r_readdata <= w_rd;
      r_irq      <= |(w_edge_next & w_mask_next);
      r_arm_sr   <= {r_arm_sr[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = r_irq;

endmodule
